rf_alu_pipe: RTL and testbench
==============================

Name: rf_alu_pipe

Overview:
- Parametrised, pipelined successor of the combinational register-file + ALU datapath.
- An issued operation reads two registers, latches the operands, executes in the ALU and writes the result back to a destination register.
- Forwarding covers back-to-back dependencies; an external write port loads registers for test and initialisation.
- Sits between the decode/control logic and the future datapath top.

Parameters:
WIDTH, 32, data word width in bits (>=8)
ADDR_W, 5, register address width; register count NREGS = 2**ADDR_W

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  issue strobe; operation accepted every cycle it is high
Read1  in  ADDR_W  source register A
Read2  in  ADDR_W  source register B
DestReg  in  ADDR_W  destination for ALU writeback
DestWrite  in  1  enable ALU writeback for this operation
ALUOp  in  2  ALU operation class
FuncCode  in  6  function field, used when ALUOp=10
WriteReg  in  ADDR_W  external write address
WriteData  in  WIDTH  external write data
RegWrite  in  1  external write enable
out_valid  out  1  ALUOut/Zero/Overflow/out_dest hold a new result
ALUOut  out  WIDTH  registered ALU result
Zero  out  1  registered (ALUOut == 0)
Overflow  out  1  registered signed overflow (add/sub only, else 0)
out_dest  out  ADDR_W  DestReg of the result on ALUOut

Behaviour:
- Reset (synchronous, active-high):
  - All NREGS registers cleared to 0; the operand stage is invalidated.
  - out_valid=0, ALUOut=0, Zero=0, Overflow=0, out_dest=0.
  - Any in-flight operation is dropped with no writeback. External writes in a reset cycle are ignored.
- Register 0 always reads 0; writes to it (ALU or external) are discarded.
- Pipeline, issue at edge k:
  - Edge k: operands A/B, DestReg, DestWrite, ALUOp and FuncCode are captured into the operand stage (S1).
  - Edge k+1: the ALU result from S1 is registered to the outputs with out_valid=1. If DestWrite and DestReg!=0, the result is written to the RF at this same edge.
  - Latency 2 edges. Throughput is 1 per cycle, with no backpressure.
  - out_valid is low on any edge where S1 was invalid. Outputs other than out_valid hold their last value.
- Operand capture priority at an issue edge, per source register src:
  1. src==0 gives 0.
  2. S1 valid, DestWrite set and DestReg==src gives the current ALU result (forward).
  3. RegWrite set and WriteReg==src gives WriteData (write-through).
  4. Otherwise the RF contents.
- Same-edge write conflict: if the ALU writeback and an external write target the same register, the ALU writeback wins. Writes to different registers both occur.
- ALU function selection:
  - ALUOp=00: add.
  - ALUOp=01: sub (A−B).
  - ALUOp=11: pass B.
  - ALUOp=10, decoded from FuncCode:
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 100110 xor
    - 100111 nor
    - 101010 slt (signed; result 1 or 0, zero-extended)
    - any other FuncCode: result 0, with Zero=1 and writeback still performed if enabled.
- Arithmetic is modulo 2**WIDTH.
  - Add overflow: operands of equal sign whose result sign differs.
  - Sub overflow: operands of differing sign whose result sign differs from A.
- Zero is computed on the registered result.

Test Plan:
- Reset with in_valid=1 asserted → out_valid=0, ALUOut=0; external write r3=5 then read r3 → 5 (reset contents are 0 before the write).
- External writes r1=7, r2=3; issue ALUOp=10/100010 r1,r2→r4 → 2 edges later ALUOut=4, Zero=0, out_dest=4; a later read of r4 gives 4.
- Back-to-back dependency: r5=r1+r2 (add) issued, then r6=r5+r1 the next cycle → ALUOut=10 then 17 (forwarded, not the stale 0).
- Writes to r0 (external and ALU) followed by read r0 → 0; forwarding never applies to r0.
- Overflow/slt: 0x7FFFFFFF+1 → ALUOut=0x80000000, Overflow=1; slt with A=0xFFFFFFFF, B=1 → 1; sub of equal values → Zero=1, Overflow=0.
- Same-edge ALU writeback and external write to r7 (ALU=9, ext=1) → r7=9. Reset asserted while S1 valid → no writeback, out_valid=0 the next cycle.

Source files
------------

// File: rtl/rf_alu_pipe.sv
// rtl/rf_alu_pipe.sv - pipelined register file + ALU with forwarding and an external write port
module rf_alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] DestReg,
  input  logic              DestWrite,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        FuncCode,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              RegWrite,
  output logic              out_valid,
  output logic [WIDTH-1:0]  ALUOut,
  output logic              Zero,
  output logic              Overflow,
  output logic [ADDR_W-1:0] out_dest
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [3:0] {
    F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_PASS, F_NONE
  } alu_fn_e;

  logic [WIDTH-1:0]  rf_q [NREGS];

  logic              s1_valid_q;
  logic [WIDTH-1:0]  s1_a_q, s1_b_q;
  logic [ADDR_W-1:0] s1_dest_q;
  logic              s1_dw_q;
  logic [1:0]        s1_op_q;
  logic [5:0]        s1_func_q;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_res_q;
  logic              out_zero_q;
  logic              out_ovf_q;
  logic [ADDR_W-1:0] out_dest_q;

  alu_fn_e           alu_fn;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ovf;
  logic [WIDTH-1:0]  sum, diff;
  logic [WIDTH-1:0]  op_a_d, op_b_d;
  logic              fwd_en;

  always_comb begin
    alu_fn = F_NONE;
    case (s1_op_q)
      2'b00: alu_fn = F_ADD;
      2'b01: alu_fn = F_SUB;
      2'b11: alu_fn = F_PASS;
      default: begin
        case (s1_func_q)
          6'b100000: alu_fn = F_ADD;
          6'b100010: alu_fn = F_SUB;
          6'b100100: alu_fn = F_AND;
          6'b100101: alu_fn = F_OR;
          6'b100110: alu_fn = F_XOR;
          6'b100111: alu_fn = F_NOR;
          6'b101010: alu_fn = F_SLT;
          default:   alu_fn = F_NONE;
        endcase
      end
    endcase
  end

  assign sum  = s1_a_q + s1_b_q;
  assign diff = s1_a_q - s1_b_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_fn)
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      F_SUB: begin
        alu_res = diff;
        alu_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      F_AND:  alu_res = s1_a_q & s1_b_q;
      F_OR:   alu_res = s1_a_q | s1_b_q;
      F_XOR:  alu_res = s1_a_q ^ s1_b_q;
      F_NOR:  alu_res = ~(s1_a_q | s1_b_q);
      F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      F_PASS: alu_res = s1_b_q;
      default: alu_res = '0;
    endcase
  end

  // Operand selection, lowest priority first so later assignments win.
  assign fwd_en = s1_valid_q && s1_dw_q;

  always_comb begin
    op_a_d = rf_q[Read1];
    if (RegWrite && (WriteReg == Read1))   op_a_d = WriteData;
    if (fwd_en && (s1_dest_q == Read1))    op_a_d = alu_res;
    if (Read1 == '0)                       op_a_d = '0;

    op_b_d = rf_q[Read2];
    if (RegWrite && (WriteReg == Read2))   op_b_d = WriteData;
    if (fwd_en && (s1_dest_q == Read2))    op_b_d = alu_res;
    if (Read2 == '0)                       op_b_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_dest_q   <= '0;
      s1_dw_q     <= 1'b0;
      s1_op_q     <= '0;
      s1_func_q   <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_dest_q  <= '0;
    end else begin
      if (RegWrite && (WriteReg != '0)) rf_q[WriteReg] <= WriteData;
      // ALU writeback comes second so it wins a same-register conflict.
      if (fwd_en && (s1_dest_q != '0)) rf_q[s1_dest_q] <= alu_res;

      s1_valid_q <= in_valid;
      s1_a_q     <= op_a_d;
      s1_b_q     <= op_b_d;
      s1_dest_q  <= DestReg;
      s1_dw_q    <= DestWrite;
      s1_op_q    <= ALUOp;
      s1_func_q  <= FuncCode;

      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_res_q  <= alu_res;
        out_zero_q <= (alu_res == '0);
        out_ovf_q  <= alu_ovf;
        out_dest_q <= s1_dest_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ALUOut    = out_res_q;
  assign Zero      = out_zero_q;
  assign Overflow  = out_ovf_q;
  assign out_dest  = out_dest_q;

endmodule

// File: tb/tb_rf_alu_pipe.sv
// tb/tb_rf_alu_pipe.sv - scoreboard bench for rf_alu_pipe against a sequential architectural model
module tb_rf_alu_pipe;

  logic        clock = 1'b0;
  logic        reset, in_valid, DestWrite, RegWrite;
  logic [4:0]  Read1, Read2, DestReg, WriteReg;
  logic [1:0]  ALUOp;
  logic [5:0]  FuncCode;
  logic [31:0] WriteData;
  logic        out_valid, Zero, Overflow;
  logic [31:0] ALUOut;
  logic [4:0]  out_dest;

  rf_alu_pipe #(.WIDTH(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .Read1(Read1), .Read2(Read2), .DestReg(DestReg), .DestWrite(DestWrite),
    .ALUOp(ALUOp), .FuncCode(FuncCode),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .out_valid(out_valid), .ALUOut(ALUOut), .Zero(Zero), .Overflow(Overflow),
    .out_dest(out_dest)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic        z;
    logic        o;
    logic [4:0]  dest;
  } res_t;

  res_t        exp_q[$];
  res_t        obs_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mrf [32];
  logic        p_v = 1'b0;
  logic        p_dw;
  logic [4:0]  p_dest;
  res_t        p_res;

  always @(posedge clock) begin
    #1;
    if (out_valid === 1'b1) obs_q.push_back('{ALUOut, Zero, Overflow, out_dest});
  end

  function automatic res_t alu_m(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] dest);
    res_t   r;
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.o = 1'b0;
    r.d = 32'd0;
    r.dest = dest;
    if (op == 2'b00 || (op == 2'b10 && fn == 6'h20)) begin
      t = sa + sb;
      r.d = t[31:0];
      r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    end else if (op == 2'b01 || (op == 2'b10 && fn == 6'h22)) begin
      t = sa - sb;
      r.d = t[31:0];
      r.o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    end else if (op == 2'b11) r.d = b;
    else if (fn == 6'h24) r.d = a & b;
    else if (fn == 6'h25) r.d = a | b;
    else if (fn == 6'h26) r.d = a ^ b;
    else if (fn == 6'h27) r.d = ~(a | b);
    else if (fn == 6'h2a) r.d = (sa < sb) ? 32'd1 : 32'd0;
    r.z = (r.d == 32'd0);
    return r;
  endfunction

  // One clock edge: ext write, then the in-flight writeback (wins), then the new op reads.
  task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input logic dw, input logic [1:0] op,
                      input logic [5:0] fn, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic rst);
    in_valid = v; Read1 = r1; Read2 = r2; DestReg = d; DestWrite = dw;
    ALUOp = op; FuncCode = fn; RegWrite = we; WriteReg = wa; WriteData = wd; reset = rst;
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      p_v = 1'b0;
    end else begin
      if (we && wa != 5'd0) mrf[wa] = wd;
      if (p_v) begin
        exp_q.push_back(p_res);
        if (p_dw && p_dest != 5'd0) mrf[p_dest] = p_res.d;
      end
      p_v = v; p_dw = dw; p_dest = d;
      if (v) p_res = alu_m(op, fn, mrf[r1], mrf[r2], d);
    end
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b1, a, d, 1'b0);
  endtask

  task automatic op(input logic [1:0] aop, input logic [5:0] fn, input logic [4:0] r1,
                    input logic [4:0] r2, input logic [4:0] d, input logic dw);
    step(1'b1, r1, r2, d, dw, aop, fn, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    res_t o, e;
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    wr(5'd1, 32'h1234);
    op(2'b11, 6'd0, 5'd0, 5'd1, 5'd9, 1'b1);
    idle(); idle();
    exp_q.delete(); obs_q.delete();
    step(1'b1, 5'd1, 5'd1, 5'd2, 1'b1, 2'b00, 6'd0, 1'b1, 5'd3, 32'd99, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ALUOut !== 32'd0) begin n_bad++; $display("FAIL reset_aluout: got %h expected 0", ALUOut); end
    n_cmp++; if ({Zero, Overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {Zero, Overflow}); end
    n_cmp++; if (out_dest !== 5'd0) begin n_bad++; $display("FAIL reset_dest: got %0d expected 0", out_dest); end
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_drop: got %b expected 0", out_valid); end
    op(2'b11, 6'd0, 5'd0, 5'd3, 5'd0, 1'b0);
    op(2'b11, 6'd0, 5'd0, 5'd9, 5'd0, 1'b0);
    wr(5'd3, 32'd5);
    op(2'b11, 6'd0, 5'd0, 5'd3, 5'd0, 1'b0);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL reset_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic();
    res_t o, e;
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd3);
    op(2'b10, 6'b100010, 5'd1, 5'd2, 5'd4, 1'b1);
    idle(); idle();
    op(2'b11, 6'd0, 5'd0, 5'd4, 5'd0, 1'b0);
    op(2'b10, 6'b100100, 5'd1, 5'd2, 5'd5, 1'b1);
    op(2'b10, 6'b100101, 5'd1, 5'd2, 5'd5, 1'b0);
    op(2'b10, 6'b100110, 5'd1, 5'd2, 5'd5, 1'b1);
    op(2'b10, 6'b100111, 5'd1, 5'd5, 5'd6, 1'b1);
    op(2'b10, 6'b111111, 5'd1, 5'd2, 5'd6, 1'b1);
    op(2'b11, 6'd0, 5'd0, 5'd6, 5'd0, 1'b0);
    wr(5'd0, 32'd55);
    op(2'b00, 6'd0, 5'd1, 5'd1, 5'd0, 1'b1);
    op(2'b00, 6'd0, 5'd0, 5'd0, 5'd8, 1'b1);
    op(2'b11, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd3);
    op(2'b00, 6'd0, 5'd1, 5'd2, 5'd5, 1'b1);
    op(2'b00, 6'd0, 5'd5, 5'd1, 5'd6, 1'b1);
    op(2'b01, 6'd0, 5'd1, 5'd6, 5'd6, 1'b1);
    op(2'b00, 6'd0, 5'd6, 5'd6, 5'd7, 1'b1);
    step(1'b1, 5'd9, 5'd7, 5'd9, 1'b1, 2'b00, 6'd0, 1'b1, 5'd9, 32'd100, 1'b0);
    op(2'b11, 6'd0, 5'd0, 5'd9, 5'd0, 1'b0);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow_slt();
    res_t o, e;
    wr(5'd1, 32'h7FFF_FFFF);
    wr(5'd2, 32'd1);
    wr(5'd3, 32'hFFFF_FFFF);
    wr(5'd4, 32'h8000_0000);
    op(2'b00, 6'd0, 5'd1, 5'd2, 5'd10, 1'b1);
    op(2'b10, 6'b101010, 5'd3, 5'd2, 5'd11, 1'b1);
    op(2'b10, 6'b101010, 5'd2, 5'd3, 5'd11, 1'b1);
    op(2'b01, 6'd0, 5'd2, 5'd2, 5'd12, 1'b1);
    op(2'b01, 6'd0, 5'd4, 5'd2, 5'd12, 1'b1);
    op(2'b10, 6'b100010, 5'd1, 5'd3, 5'd13, 1'b1);
    op(2'b10, 6'b100000, 5'd4, 5'd4, 5'd13, 1'b1);
    op(2'b10, 6'b100100, 5'd4, 5'd4, 5'd14, 1'b1);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL ovf_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ovf_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_conflict_reset();
    res_t o, e;
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd2);
    op(2'b00, 6'd0, 5'd1, 5'd2, 5'd7, 1'b1);
    wr(5'd7, 32'd1);
    op(2'b11, 6'd0, 5'd0, 5'd7, 5'd0, 1'b0);
    wr(5'd8, 32'd3);
    op(2'b00, 6'd0, 5'd1, 5'd8, 5'd15, 1'b1);
    step(1'b1, 5'd1, 5'd2, 5'd16, 1'b1, 2'b11, 6'd0, 1'b1, 5'd8, 32'd50, 1'b0);
    op(2'b11, 6'd0, 5'd0, 5'd15, 5'd0, 1'b0);
    op(2'b11, 6'd0, 5'd0, 5'd8, 5'd0, 1'b0);
    idle(); idle();
    op(2'b00, 6'd0, 5'd1, 5'd1, 5'd17, 1'b1);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inflight_valid: got %b expected 0", out_valid); end
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inflight_next: got %b expected 0", out_valid); end
    op(2'b11, 6'd0, 5'd0, 5'd17, 5'd0, 1'b0);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL conflict_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL conflict_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    res_t        o, e;
    logic [5:0]  fns [8];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h3f};
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           fns[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFF0 + 32'($urandom_range(0, 31)) : 32'($urandom),
           1'b0);
    end
    for (int i = 0; i < 8; i++) op(2'b11, 6'd0, 5'd0, 5'(i), 5'd0, 1'b0);
    idle(); idle();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL random_result: got d=%h z=%b o=%b dest=%0d expected d=%h z=%b o=%b dest=%0d", o.d, o.z, o.o, o.dest, e.d, e.z, e.o, e.dest); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow_slt();
    test_conflict_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
